vgachargen_core: RTL and testbench
==================================

VGACHARGEN_CORE -- requirements
Module: vgachargen

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter: CLK_DIV, default 4, clk_i cycles per VGA pixel (100 MHz clk_i -> 25 MHz pixel rate).
REQ-003 clk_i  in  1  system clock; all logic, bus ports and VGA timing run on it.
REQ-004 rst_i  in  1  asynchronous active-low reset.
REQ-005 char_map_addr_i / char_map_ce_i / char_map_we_i / char_map_be_i / char_map_wdata_i  in  10/1/1/4/32  character-code map port; word address, enable, write, byte enables, write data.
REQ-006 char_map_rdata_o  out  32  character-code map read data.
REQ-007 col_map_addr_i / col_map_ce_i / col_map_we_i / col_map_be_i / col_map_wdata_i  in  10/1/1/4/32  colour-scheme map port, same signalling as REQ-005.
REQ-008 col_map_rdata_o  out  32  colour-scheme map read data.
REQ-009 char_tiff_addr_i / char_tiff_ce_i / char_tiff_we_i / char_tiff_be_i / char_tiff_wdata_i  in  10/1/1/4/32  font (glyph bitmap) memory port, same signalling.
REQ-010 char_tiff_rdata_o  out  32  font memory read data.
REQ-011 vga_r_o, vga_g_o, vga_b_o  out  4 each  VGA colour channels; vga_hs_o, vga_vs_o  out  1 each  syncs, active-low.

Function
REQ-012 Char map: 600 x 32 bit; byte k of word w = ASCII code of character n = 4w+k; screen 80 x 30 chars, n = row*80+col.
REQ-013 Colour map: 600 x 32 bit, same byte mapping; byte[7:4] = background palette index, byte[3:0] = foreground palette index.
REQ-014 Font memory: 1024 x 32 bit; glyph c (8 x 16 px) occupies words 4c..4c+3; pixel row y in byte (y mod 4) of word 4c + y/4; pixel column x (0 = leftmost) is bit x of that byte; 1 = foreground.
REQ-015 Bus write: at clk_i edge with ce=1 and we=1, byte i of addressed word updated from wdata byte i iff be[i]=1.
REQ-016 Bus read: at clk_i edge with ce=1, rdata register loads addressed word; data valid from that edge until next ce read (1-cycle latency); rdata holds when ce=0.
REQ-017 Simultaneous read and write of same word returns pre-write contents (read-first).
REQ-018 Addresses >= 600 on char/col map: writes ignored, reads return 0.
REQ-019 Display fetch uses a separate internal read port on each memory; bus traffic never stalls or corrupts the display.
REQ-020 Pixel enable pulses once every CLK_DIV clk_i cycles; h/v counters advance only on it.
REQ-021 Horizontal: 800 pixels total; visible 0-639, front porch 16, sync 96 (hs low for h = 656-751), back porch 48.
REQ-022 Vertical: 525 lines total; visible 0-479, front porch 10, sync 2 (vs low for v = 490-491), back porch 33; v increments when h wraps 799->0; v wraps 524->0.
REQ-023 Visible pixel (h,v): col = h/8, row = v/16, x = h mod 8, y = v mod 16; colour = palette[fg] if font bit set else palette[bg].
REQ-024 Palette: fixed 16-entry 12-bit RGB table, standard CGA/VGA-16 colours (0 black, 7 light grey, 15 white).
REQ-025 Fetch pipeline is internal; hs, vs and RGB are delayed equally so all three stay aligned to the same (h,v).
REQ-026 Outside visible area RGB = 0.

Reset
REQ-027 During reset: h=v=0, pixel divider 0, RGB=0, hs=vs=1, all rdata outputs 0.
REQ-028 Memory contents not reset; reset mid-frame restarts timing at (0,0) on release; reset mid-bus-access discards that access.

Verification
REQ-029 Write col map words 0-599 with {4{i[7:0]}}, be=1111; read back 0-599 -> each rdata equals {4{i[7:0]}} one cycle after address edge.
REQ-030 Write char map words 0-599 with i, read back -> rdata = i for all words; read addr 600 -> 0.
REQ-031 Write font words 0-1023 with i, read back -> rdata = i for all words.
REQ-032 Write 0xFFFFFFFF then 0x00000000 with be=0101 -> readback 0xFF00FF00.
REQ-033 After reset, count clk_i: hs period 3200 cycles, hs low 384 cycles; vs period 1,680,000 cycles, vs low 2 lines.
REQ-034 Char 0 = 'A', colour 0x1F, glyph 'A' loaded -> first line pixels show white-on-blue pattern matching font bits; blank areas RGB=0.

Source files
------------

// File: rtl/vgachargen_core.sv
// 80x30 text-mode VGA character generator: three bus-accessible memories (char codes,
// colour schemes, font) and a 640x480@60 raster with a three-stage fetch pipeline.

module vgachargen_ram #(
  parameter int DEPTH = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [9:0]  addr_i,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic [9:0]  disp_addr_i,
  output logic [31:0] disp_data_o
);
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;
  logic [31:0] r_disp;
  logic        w_bus_ok;
  logic        w_disp_ok;

  generate
    if (DEPTH < 1024) begin : g_part
      assign w_bus_ok  = addr_i < 10'(DEPTH);
      assign w_disp_ok = disp_addr_i < 10'(DEPTH);
    end else begin : g_full
      assign w_bus_ok  = 1'b1;
      assign w_disp_ok = 1'b1;
    end
  endgenerate

  // Contents are never reset; a write landing while reset is held is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i && ce_i && we_i && w_bus_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) r_mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    r_disp <= w_disp_ok ? r_mem[disp_addr_i] : '0;
  end

  // Read-first: the non-blocking write above is not visible to this read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdata <= '0;
    end else if (ce_i) begin
      r_rdata <= w_bus_ok ? r_mem[addr_i] : '0;
    end
  end

  assign rdata_o     = r_rdata;
  assign disp_data_o = r_disp;
endmodule

module vgachargen_core #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [9:0]  char_map_addr_i,
  input  logic        char_map_ce_i,
  input  logic        char_map_we_i,
  input  logic [3:0]  char_map_be_i,
  input  logic [31:0] char_map_wdata_i,
  output logic [31:0] char_map_rdata_o,
  input  logic [9:0]  col_map_addr_i,
  input  logic        col_map_ce_i,
  input  logic        col_map_we_i,
  input  logic [3:0]  col_map_be_i,
  input  logic [31:0] col_map_wdata_i,
  output logic [31:0] col_map_rdata_o,
  input  logic [9:0]  char_tiff_addr_i,
  input  logic        char_tiff_ce_i,
  input  logic        char_tiff_we_i,
  input  logic [3:0]  char_tiff_be_i,
  input  logic [31:0] char_tiff_wdata_i,
  output logic [31:0] char_tiff_rdata_o,
  output logic [3:0]  vga_r_o,
  output logic [3:0]  vga_g_o,
  output logic [3:0]  vga_b_o,
  output logic        vga_hs_o,
  output logic        vga_vs_o
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] r_div;
  logic          w_pix_en;
  logic [9:0]    r_h;
  logic [9:0]    r_v;

  assign w_pix_en = (r_div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_pix_en ? '0 : r_div + 1'b1;
      if (w_pix_en) begin
        if (r_h == 10'd799) begin
          r_h <= '0;
          r_v <= (r_v == 10'd524) ? '0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end
    end
  end

  // Stage 0: raster position -> character index; char and colour words are read.
  logic        w_vis0;
  logic        w_hs0;
  logic        w_vs0;
  logic [4:0]  w_row;
  logic [11:0] w_char_idx;
  logic [9:0]  w_map_addr;

  assign w_vis0     = (r_h < 10'd640) && (r_v < 10'd480);
  assign w_hs0      = !((r_h >= 10'd656) && (r_h < 10'd752));
  assign w_vs0      = !((r_v >= 10'd490) && (r_v < 10'd492));
  assign w_row      = r_v[8:4];
  assign w_char_idx = 12'({w_row, 6'd0}) + 12'({w_row, 4'd0}) + 12'(r_h[9:3]);
  assign w_map_addr = w_vis0 ? w_char_idx[11:2] : '0;

  logic [31:0] w_char_dout;
  logic [31:0] w_col_dout;
  logic [31:0] w_font_dout;
  logic [9:0]  w_font_addr;

  vgachargen_ram #(.DEPTH(600)) u_char_map (
    .clk_i(clk_i), .rst_i(rst_i),
    .addr_i(char_map_addr_i), .ce_i(char_map_ce_i), .we_i(char_map_we_i),
    .be_i(char_map_be_i), .wdata_i(char_map_wdata_i), .rdata_o(char_map_rdata_o),
    .disp_addr_i(w_map_addr), .disp_data_o(w_char_dout)
  );

  vgachargen_ram #(.DEPTH(600)) u_col_map (
    .clk_i(clk_i), .rst_i(rst_i),
    .addr_i(col_map_addr_i), .ce_i(col_map_ce_i), .we_i(col_map_we_i),
    .be_i(col_map_be_i), .wdata_i(col_map_wdata_i), .rdata_o(col_map_rdata_o),
    .disp_addr_i(w_map_addr), .disp_data_o(w_col_dout)
  );

  vgachargen_ram #(.DEPTH(1024)) u_font (
    .clk_i(clk_i), .rst_i(rst_i),
    .addr_i(char_tiff_addr_i), .ce_i(char_tiff_ce_i), .we_i(char_tiff_we_i),
    .be_i(char_tiff_be_i), .wdata_i(char_tiff_wdata_i), .rdata_o(char_tiff_rdata_o),
    .disp_addr_i(w_font_addr), .disp_data_o(w_font_dout)
  );

  // Stage 1: pick the character's byte lane, address its glyph row word.
  logic [1:0] r1_byte;
  logic [2:0] r1_x;
  logic [3:0] r1_y;
  logic       r1_vis;
  logic       r1_hs;
  logic       r1_vs;
  logic [7:0] w_code;
  logic [7:0] w_colb;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r1_byte <= '0;
      r1_x    <= '0;
      r1_y    <= '0;
      r1_vis  <= 1'b0;
      r1_hs   <= 1'b1;
      r1_vs   <= 1'b1;
    end else begin
      r1_byte <= w_char_idx[1:0];
      r1_x    <= r_h[2:0];
      r1_y    <= r_v[3:0];
      r1_vis  <= w_vis0;
      r1_hs   <= w_hs0;
      r1_vs   <= w_vs0;
    end
  end

  assign w_code      = w_char_dout[{r1_byte, 3'b000} +: 8];
  assign w_colb      = w_col_dout[{r1_byte, 3'b000} +: 8];
  assign w_font_addr = {w_code, r1_y[3:2]};

  // Stage 2: select the glyph row byte and pixel bit, then map through the palette.
  logic [7:0] r2_col;
  logic [2:0] r2_x;
  logic [1:0] r2_yb;
  logic       r2_vis;
  logic       r2_hs;
  logic       r2_vs;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r2_col <= '0;
      r2_x   <= '0;
      r2_yb  <= '0;
      r2_vis <= 1'b0;
      r2_hs  <= 1'b1;
      r2_vs  <= 1'b1;
    end else begin
      r2_col <= w_colb;
      r2_x   <= r1_x;
      r2_yb  <= r1_y[1:0];
      r2_vis <= r1_vis;
      r2_hs  <= r1_hs;
      r2_vs  <= r1_vs;
    end
  end

  logic [7:0]  w_font_byte;
  logic        w_bit;
  logic [3:0]  w_pal_idx;
  logic [11:0] w_pal_rgb;

  assign w_font_byte = w_font_dout[{r2_yb, 3'b000} +: 8];
  assign w_bit       = w_font_byte[r2_x];
  assign w_pal_idx   = w_bit ? r2_col[3:0] : r2_col[7:4];

  always_comb begin
    w_pal_rgb = 12'h000;
    case (w_pal_idx)
      4'd0:  w_pal_rgb = 12'h000;
      4'd1:  w_pal_rgb = 12'h00A;
      4'd2:  w_pal_rgb = 12'h0A0;
      4'd3:  w_pal_rgb = 12'h0AA;
      4'd4:  w_pal_rgb = 12'hA00;
      4'd5:  w_pal_rgb = 12'hA0A;
      4'd6:  w_pal_rgb = 12'hA50;
      4'd7:  w_pal_rgb = 12'hAAA;
      4'd8:  w_pal_rgb = 12'h555;
      4'd9:  w_pal_rgb = 12'h55F;
      4'd10: w_pal_rgb = 12'h5F5;
      4'd11: w_pal_rgb = 12'h5FF;
      4'd12: w_pal_rgb = 12'hF55;
      4'd13: w_pal_rgb = 12'hF5F;
      4'd14: w_pal_rgb = 12'hFF5;
      4'd15: w_pal_rgb = 12'hFFF;
      default: w_pal_rgb = 12'h000;
    endcase
  end

  // Output register keeps RGB and both syncs on the same raster position.
  logic [11:0] r_rgb;
  logic        r_hs;
  logic        r_vs;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rgb <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else begin
      r_rgb <= r2_vis ? w_pal_rgb : 12'h000;
      r_hs  <= r2_hs;
      r_vs  <= r2_vs;
    end
  end

  assign vga_r_o  = r_rgb[11:8];
  assign vga_g_o  = r_rgb[7:4];
  assign vga_b_o  = r_rgb[3:0];
  assign vga_hs_o = r_hs;
  assign vga_vs_o = r_vs;
endmodule

// File: tb/tb_vgachargen_core.sv
// Bench for vgachargen_core: bus port read/write checks plus a per-cycle raster
// model of the text display derived from the memory contents the bench wrote.

module tb_vgachargen_core;
  localparam int CLK_DIV = 4;
  localparam logic [11:0] PAL [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

  // clock / reset
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  a  [3];
  logic        ce [3];
  logic        we [3];
  logic [3:0]  be [3];
  logic [31:0] wd [3];
  logic [31:0] rd [3];
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;
  logic [11:0] rgb;
  assign rgb = {vga_r, vga_g, vga_b};

  vgachargen_core #(.CLK_DIV(CLK_DIV)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .char_map_addr_i(a[0]), .char_map_ce_i(ce[0]), .char_map_we_i(we[0]),
    .char_map_be_i(be[0]), .char_map_wdata_i(wd[0]), .char_map_rdata_o(rd[0]),
    .col_map_addr_i(a[1]), .col_map_ce_i(ce[1]), .col_map_we_i(we[1]),
    .col_map_be_i(be[1]), .col_map_wdata_i(wd[1]), .col_map_rdata_o(rd[1]),
    .char_tiff_addr_i(a[2]), .char_tiff_ce_i(ce[2]), .char_tiff_we_i(we[2]),
    .char_tiff_be_i(be[2]), .char_tiff_wdata_i(wd[2]), .char_tiff_rdata_o(rd[2]),
    .vga_r_o(vga_r), .vga_g_o(vga_g), .vga_b_o(vga_b),
    .vga_hs_o(vga_hs), .vga_vs_o(vga_vs)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int j = 0;          // clock edges since reset release
  int lat = 0;        // measured output latency in clk cycles
  bit checking = 0;
  bit prev_hs = 1;
  int falls[$];
  int rises[$];
  logic [31:0] mem_m [3][1024];
  logic [31:0] exp_q[$];

  always @(posedge clk) j <= rst_i ? j + 1 : 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // driver: one bus operation; read data is checked one cycle after the address edge
  task automatic bus_op(input int p, input logic [9:0] addr, input logic w,
                        input logic [3:0] bm, input logic [31:0] d,
                        input logic do_chk, input logic [31:0] exp, input string nm);
    @(posedge clk); #1;
    a[p] = addr; ce[p] = 1'b1; we[p] = w; be[p] = bm; wd[p] = d;
    @(posedge clk); #1;
    ce[p] = 1'b0; we[p] = 1'b0;
    if (w && (p == 2 || addr < 10'd600))
      for (int b = 0; b < 4; b++) if (bm[b]) mem_m[p][addr][8*b +: 8] = d[8*b +: 8];
    if (do_chk) chk(nm, rd[p], exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
  endtask

  // model: what the screen shows at raster pixel index p counted from (0,0)
  function automatic void model_px(input int p, output logic [11:0] m_rgb,
                                   output logic m_hs, output logic m_vs);
    int h, v, n;
    logic [7:0] code, colb, fb;
    logic [31:0] fw;
    h = p % 800;
    v = (p / 800) % 525;
    m_hs = !(h >= 656 && h < 752);
    m_vs = !(v >= 490 && v < 492);
    m_rgb = 12'h000;
    if (h < 640 && v < 480) begin
      n = (v / 16) * 80 + h / 8;
      code = mem_m[0][n / 4][8 * (n % 4) +: 8];
      colb = mem_m[1][n / 4][8 * (n % 4) +: 8];
      fw = mem_m[2][code * 4 + (v % 16) / 4];
      fb = fw[8 * (v % 4) +: 8];
      m_rgb = fb[h % 8] ? PAL[colb[3:0]] : PAL[colb[7:4]];
    end
  endfunction

  // scoreboard: compare every cycle of the check window against the model
  always @(negedge clk) begin
    logic [11:0] e_rgb;
    logic e_hs, e_vs;
    int p;
    if (checking && j >= lat) begin
      p = (j - lat) / CLK_DIV;
      model_px(p, e_rgb, e_hs, e_vs);
      chk($sformatf("pix h=%0d v=%0d", p % 800, (p / 800) % 525),
          {18'd0, rgb, vga_hs, vga_vs}, {18'd0, e_rgb, e_hs, e_vs});
      if (j == lat + 2)  chk("A_x0_bg",  {20'd0, rgb}, 32'h00A);
      if (j == lat + 6)  chk("A_x1_fg",  {20'd0, rgb}, 32'hFFF);
      if (j == lat + 18) chk("A_x4_fg",  {20'd0, rgb}, 32'hFFF);
      if (j == lat + 22) chk("A_x5_bg",  {20'd0, rgb}, 32'h00A);
      if (j == lat + 30) chk("A_x7_bg",  {20'd0, rgb}, 32'h00A);
      if (j == lat + 4 * 700 + 2) chk("blank_h700", {19'd0, rgb, vga_hs}, 32'h0);
      if (prev_hs && !vga_hs) falls.push_back(j);
      if (!prev_hs && vga_hs) rises.push_back(j);
      prev_hs = vga_hs;
    end
  end

  logic [7:0] glyph [16] = '{8'h1E, 8'h33, 8'h33, 8'h33, 8'h3F, 8'h33, 8'h33, 8'h33,
                             8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    logic [11:0] e_rgb;
    logic e_hs, e_vs;
    bit found;
    for (int p = 0; p < 3; p++) begin
      a[p] = '0; ce[p] = 1'b0; we[p] = 1'b0; be[p] = '0; wd[p] = '0;
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_char", rd[0], 32'h0);
    chk("rst_rd_col",  rd[1], 32'h0);
    chk("rst_rd_font", rd[2], 32'h0);
    chk("rst_rgb", {20'd0, rgb}, 32'h0);
    chk("rst_syncs", {30'd0, vga_hs, vga_vs}, 32'h3);
    @(posedge clk); #1 rst_i = 1'b1;

    // colour map fill / readback
    for (int i = 0; i < 600; i++) bus_op(1, 10'(i), 1, 4'hF, {4{8'(i)}}, 0, 0, "");
    for (int i = 0; i < 600; i++) bus_op(1, 10'(i), 0, 4'h0, 0, 1, {4{8'(i)}}, "col_rd");
    // char map fill / readback, out-of-range address
    for (int i = 0; i < 600; i++) bus_op(0, 10'(i), 1, 4'hF, 32'(i), 0, 0, "");
    for (int i = 0; i < 600; i++) bus_op(0, 10'(i), 0, 4'h0, 0, 1, 32'(i), "char_rd");
    bus_op(0, 10'd600, 1, 4'hF, 32'h12345678, 0, 0, "");
    bus_op(0, 10'd600, 0, 4'h0, 0, 1, 32'h0, "char_rd600");
    bus_op(0, 10'd1023, 0, 4'h0, 0, 1, 32'h0, "char_rd1023");
    bus_op(0, 10'd599, 0, 4'h0, 0, 1, 32'd599, "char_rd599");
    // font fill / readback
    for (int i = 0; i < 1024; i++) bus_op(2, 10'(i), 1, 4'hF, 32'(i), 0, 0, "");
    for (int i = 0; i < 1024; i++) bus_op(2, 10'(i), 0, 4'h0, 0, 1, 32'(i), "font_rd");

    // byte enables, read-first, hold
    bus_op(0, 10'd10, 1, 4'hF, 32'hFFFFFFFF, 0, 0, "");
    bus_op(0, 10'd10, 1, 4'b0101, 32'h00000000, 0, 0, "");
    bus_op(0, 10'd10, 0, 4'h0, 0, 1, 32'hFF00FF00, "be_0101");
    bus_op(1, 10'd7, 1, 4'hF, 32'hA5A55A5A, 1, 32'h07070707, "read_first");
    bus_op(1, 10'd7, 0, 4'h0, 0, 1, 32'hA5A55A5A, "after_write");
    repeat (3) @(posedge clk);
    #1 chk("rd_hold", rd[1], 32'hA5A55A5A);

    // reset asserted during a write: access discarded, rdata cleared
    @(posedge clk); #1;
    a[1] = 10'd5; ce[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; wd[1] = 32'hDEADBEEF;
    rst_i = 1'b0;
    @(posedge clk); #1;
    ce[1] = 1'b0; we[1] = 1'b0;
    chk("midrst_rdata", rd[1], 32'h0);
    chk("midrst_syncs", {19'd0, rgb, vga_hs}, 32'h1);
    rst_i = 1'b1;
    bus_op(1, 10'd5, 0, 4'h0, 0, 1, 32'h05050505, "midrst_discard");

    // 'A' white-on-blue in character 0
    bus_op(0, 10'd0, 1, 4'b0001, 32'h00000041, 0, 0, "");
    bus_op(1, 10'd0, 1, 4'b0001, 32'h0000001F, 0, 0, "");
    for (int q = 0; q < 4; q++)
      bus_op(2, 10'(32'h104 + q), 1, 4'hF,
             {glyph[4*q+3], glyph[4*q+2], glyph[4*q+1], glyph[4*q]}, 0, 0, "");

    // pin the model with hand-computed values
    model_px(0, e_rgb, e_hs, e_vs);        chk("model_px0", {20'd0, e_rgb}, 32'h00A);
    model_px(1, e_rgb, e_hs, e_vs);        chk("model_px1", {20'd0, e_rgb}, 32'hFFF);
    model_px(640, e_rgb, e_hs, e_vs);      chk("model_h640", {20'd0, e_rgb}, 32'h0);
    model_px(656, e_rgb, e_hs, e_vs);      chk("model_hs656", {31'd0, e_hs}, 32'h0);
    model_px(800 * 490, e_rgb, e_hs, e_vs); chk("model_vs490", {31'd0, e_vs}, 32'h0);

    // locate raster alignment from the first hs falling edge (h = 656)
    do_reset();
    found = 0;
    for (int c = 0; c < 4000 && !found; c++) begin
      @(negedge clk);
      if (!vga_hs) found = 1;
    end
    lat = j - 656 * CLK_DIV;
    n_tests++;
    if (!found || lat < 1 || lat > 16) begin
      n_fail++;
      $display("FAIL latency: found=%0d got %0d cycles, required 1..16", found, lat);
    end else begin
      do_reset();
      prev_hs = 1;
      checking = 1;
      fork
        repeat (18 * 800 * CLK_DIV) @(posedge clk);
        begin
          for (int w = 0; w < 30; w++) exp_q.push_back(mem_m[0][w]);
          for (int w = 0; w < 30; w++) bus_op(0, 10'(w), 0, 4'h0, 0, 1, exp_q.pop_front(), "win_rd");
        end
      join
      @(negedge clk);
      checking = 0;
      n_tests++;
      if (falls.size() < 2 || rises.size() < 1) begin
        n_fail++;
        $display("FAIL hs_edges: got %0d falls %0d rises, required >=2 and >=1",
                 falls.size(), rises.size());
      end else begin
        chk("hs_period", 32'(falls[1] - falls[0]), 32'd3200);
        chk("hs_low", 32'(rises[0] - falls[0]), 32'd384);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
